// File: rtl/debug_slave_resp.sv
// Debug-port slave: CTRL/STATUS/scratch register file with fixed read latency and one outstanding transaction.
// Optional build macro DEBUG_RESP_PARITY_EN: even parity on bit 64 of write data and read data.
module debug_slave_resp #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [64:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [64:0]           rdata_o,
  input  logic                  halted_i,
  output logic                  halt_req_o,
  output logic                  resume_req_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LATENCY - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [3:0]  idx;
  logic        oor;
  logic        par_ok;
  logic        par_set;
  logic        wr_ok;
  logic        halt_q;
  logic        resume_q;
  logic        addr_err_q;
  logic        par_err_q;
  logic [64:0] scratch_q [2:15];
  logic [64:0] rd_val;
  logic [64:0] resp_d, resp_q;

  assign idx = addr_i[6:3];
  assign oor = (addr_i >> 7) != '0;

`ifdef DEBUG_RESP_PARITY_EN
  assign par_ok  = (^wdata_i[63:0]) == wdata_i[64];
  assign par_set = gnt_o & we_i & ~par_ok;
`else
  assign par_ok  = 1'b1;
  assign par_set = 1'b0;
`endif

  assign gnt_o        = req_i & ~rst_i & ((state_q == IDLE) | (state_q == RESP));
  assign wr_ok        = gnt_o & we_i & ~oor & par_ok;
  assign rvalid_o     = (state_q == RESP);
  assign rdata_o      = rvalid_o ? resp_q : '0;
  assign halt_req_o   = halt_q;
  assign resume_req_o = resume_q;

  always_comb begin
    rd_val = '0;
    case (idx)
      4'd0: rd_val[0] = halt_q;
      4'd1: begin
        rd_val[0] = halted_i;
        rd_val[1] = addr_err_q;
        rd_val[2] = par_err_q;
      end
      default: rd_val = scratch_q[idx];
    endcase
  end

  // Writes and out-of-range reads answer with zero; parity is fixed up at capture time.
  always_comb begin
    resp_d = (we_i | oor) ? '0 : rd_val;
`ifdef DEBUG_RESP_PARITY_EN
    resp_d[64] = ^resp_d[63:0];
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      halt_q     <= 1'b0;
      resume_q   <= 1'b0;
      addr_err_q <= 1'b0;
      par_err_q  <= 1'b0;
      resp_q     <= '0;
      for (int unsigned i = 2; i < 16; i++) scratch_q[i] <= '0;
    end else begin
      resume_q <= wr_ok & (idx == 4'd0) & wdata_i[1];
      if (wr_ok && idx == 4'd0) halt_q <= wdata_i[0];
      // Sticky set has priority over the W1C clear.
      addr_err_q <= (gnt_o & oor) | (addr_err_q & ~(wr_ok & (idx == 4'd1) & wdata_i[1]));
      par_err_q  <= par_set | (par_err_q & ~(wr_ok & (idx == 4'd1) & wdata_i[2]));
      if (wr_ok && idx >= 4'd2) scratch_q[idx] <= wdata_i;
      if (gnt_o) resp_q <= resp_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (gnt_o) begin
          cnt_d   = LAT_M1;
          state_d = (LAT_M1 == 2'd0) ? RESP : WAIT;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) state_d = RESP;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: doc/debug_slave_resp.md
DEBUG_SLAVE_RESP -- requirements
Module: debug_slave_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 15: byte address width of the debug port.
REQ-002 SHALL have parameter RD_LATENCY, default 1, legal range 1..4: cycles from grant to rvalid.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port req_i, input, 1: request from the debug master.
REQ-006 SHALL have port gnt_o, output, 1: request accepted this cycle.
REQ-007 SHALL have port addr_i, input, ADDR_WIDTH: byte address.
REQ-008 SHALL have port we_i, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port wdata_i, input, 65: write data.
REQ-010 SHALL have port rvalid_o, output, 1: response valid.
REQ-011 SHALL have port rdata_o, output, 65: read data, qualified by rvalid_o.
REQ-012 SHALL have port halted_i, input, 1: core halted status.
REQ-013 SHALL have port halt_req_o, output, 1: level halt request to the core.
REQ-014 SHALL have port resume_req_o, output, 1: one-cycle resume pulse.

Function
REQ-015 SHALL decode word index = addr_i[6:3]; addr_i[2:0] ignored; any nonzero addr_i[ADDR_WIDTH-1:7] is out-of-range.
REQ-016 SHALL map index 0 = CTRL (bit0 halt_req, R/W; bit1 resume, write-1 pulses, reads 0), index 1 = STATUS (bit0 halted_i, bit1 addr_err sticky, bit2 par_err sticky, W1C on bits 1-2), indices 2..15 = 65-bit scratch registers; unused bits read 0.
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; gnt_o = req_i AND (state is IDLE or RESP), combinational.
REQ-018 On grant SHALL apply writes at that clock edge and capture read data (register value before the edge) into a response register.
REQ-019 On grant SHALL load latency counter with RD_LATENCY-1 and enter RESP if it is 0, else WAIT; WAIT decrements and enters RESP at 0.
REQ-020 In RESP SHALL drive rvalid_o=1 for exactly one cycle, then go to IDLE, or reload per REQ-019 if a new grant occurs in the same cycle (back-to-back, one response per cycle when RD_LATENCY=1).
REQ-021 SHALL return rdata_o = 0 for write responses and out-of-range reads; rdata_o = 0 whenever rvalid_o = 0.
REQ-022 Out-of-range access SHALL still be granted and answered, write discarded, STATUS.addr_err set.
REQ-023 resume_req_o SHALL assert the cycle after a granted CTRL write with wdata_i[1]=1, for one cycle only.
REQ-024 Sticky-set and W1C on the same cycle: set wins.
REQ-025 At most one transaction SHALL be outstanding; req_i in WAIT is not granted.

Reset
REQ-026 On rst_i high SHALL immediately force state IDLE, counter 0, gnt_o path disabled, rvalid_o=0, rdata_o=0, halt_req_o=0, resume_req_o=0, all registers and sticky bits 0.
REQ-027 Reset mid-transaction SHALL drop the pending response; no rvalid_o after rst_i deasserts without a new grant.

Configuration
REQ-028 With DEBUG_RESP_PARITY_EN defined, wdata_i[64] SHALL be even parity over wdata_i[63:0]; a write with wrong parity is discarded, still answered, and sets STATUS.par_err; rdata_o[64] is generated as even parity of rdata_o[63:0].
REQ-029 Without DEBUG_RESP_PARITY_EN, bit 64 SHALL be an ordinary stored/returned data bit and STATUS bit2 reads 0.

Verification
REQ-030 RD_LATENCY=1: write 0x0_DEAD_BEEF_0000_0001 to addr 0x10, read addr 0x10 next cycle -> gnt same cycle, rvalid one cycle after each grant, read data matches (bit64 per config).
REQ-031 RD_LATENCY=3: read held high continuously -> grants spaced 3 cycles, rvalid exactly 3 cycles after each grant, req_i ignored in WAIT.
REQ-032 Read addr 0x80 -> rdata 0, STATUS reads 0x2; write STATUS 0x2 -> STATUS reads 0x0.
REQ-033 Write CTRL 0x3 -> halt_req_o=1 held, resume_req_o high exactly one cycle; CTRL reads 0x1.
REQ-034 Parity build: write addr 0x18 with wrong bit64 -> register unchanged, STATUS bit2=1, rvalid still returned.
REQ-035 Assert rst_i during WAIT -> rvalid_o never asserts for that request; all outputs 0 immediately.
